// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation encoding,
// pipeline depth limit, and decode of the operation code into sub/sat flags.
package adder_pkg;

    localparam int ADDER_MAX_STAGES = 4;

    typedef enum logic [1:0] {
        ADD     = 2'b00,
        SUB     = 2'b01,
        ADD_SAT = 2'b10,
        SUB_SAT = 2'b11
    } adder_op_t;

    function automatic logic op_is_sub(input adder_op_t op);
        case (op)
            SUB, SUB_SAT: op_is_sub = 1'b1;
            default:      op_is_sub = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_sat(input adder_op_t op);
        case (op)
            ADD_SAT, SUB_SAT: op_is_sat = 1'b1;
            default:          op_is_sat = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry-chain slice: SW-bit add with carry in and carry out.
module adder_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          c_i,
    output logic [SW-1:0] sum_o,
    output logic          c_o
);

    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined adder/subtractor, carry chain split into STAGES slices.
// Define PIPELINED_ADDER_SAT_EN to build the saturating ADD_SAT/SUB_SAT variants.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > ADDER_MAX_STAGES || WIDTH < 8 || WIDTH > 64 ||
        (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    // Entry k of each array is the input of stage k; entry 0 is the accepted beat.
    logic             v_p [STAGES];
    logic [WIDTH-1:0] a_p [STAGES];
    logic [WIDTH-1:0] b_p [STAGES];
    logic [WIDTH-1:0] s_p [STAGES];
    logic             c_p [STAGES];
`ifdef PIPELINED_ADDER_SAT_EN
    logic             sat_p [STAGES];
`endif

    logic             adv_s;
    logic             is_sub_s;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_carry_q;
    logic             out_ovf_q;
    logic             out_zero_q;

    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = adv_s;
    assign is_sub_s = op_is_sub(adder_op_t'(in_op));

    // Subtraction is a + ~b + 1: invert B up front and feed the +1 as carry-in.
    assign v_p[0] = in_valid;
    assign a_p[0] = in_a;
    assign b_p[0] = is_sub_s ? ~in_b : in_b;
    assign s_p[0] = {WIDTH{1'b0}};
    assign c_p[0] = is_sub_s;
`ifdef PIPELINED_ADDER_SAT_EN
    assign sat_p[0] = op_is_sat(adder_op_t'(in_op));
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    sl_sum_s;
        logic             sl_c_s;
        logic [WIDTH-1:0] sum_s;

        adder_slice #(.SW(SW)) u_slice (
            .a_i   (a_p[k][k*SW +: SW]),
            .b_i   (b_p[k][k*SW +: SW]),
            .c_i   (c_p[k]),
            .sum_o (sl_sum_s),
            .c_o   (sl_c_s)
        );

        // Merge this slice's result into the partially built sum.
        always_comb begin
            sum_s = s_p[k];
            sum_s[k*SW +: SW] = sl_sum_s;
        end

        if (k < STAGES - 1) begin : g_mid
            logic             v_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
`ifdef PIPELINED_ADDER_SAT_EN
            logic             sat_q;

            // Saturation flag travels with its beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sat_q <= 1'b0;
                end else if (adv_s) begin
                    sat_q <= sat_p[k];
                end
            end
            assign sat_p[k+1] = sat_q;
`endif

            // Intermediate stage register; holds whenever the output is stalled.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    a_q <= {WIDTH{1'b0}};
                    b_q <= {WIDTH{1'b0}};
                    s_q <= {WIDTH{1'b0}};
                    c_q <= 1'b0;
                end else if (adv_s) begin
                    v_q <= v_p[k];
                    a_q <= a_p[k];
                    b_q <= b_p[k];
                    s_q <= sum_s;
                    c_q <= sl_c_s;
                end
            end

            assign v_p[k+1] = v_q;
            assign a_p[k+1] = a_q;
            assign b_p[k+1] = b_q;
            assign s_p[k+1] = sum_s_fwd(s_q);
            assign c_p[k+1] = c_q;
        end else begin : g_last
            logic             ovf_s;
            logic [WIDTH-1:0] res_s;

            // Overflow: both effective operands share a sign the result lacks.
            assign ovf_s = (a_p[k][WIDTH-1] == b_p[k][WIDTH-1]) &&
                           (sum_s[WIDTH-1] != a_p[k][WIDTH-1]);

`ifdef PIPELINED_ADDER_SAT_EN
            // Clamp toward the sign of A, which is the direction of overflow.
            always_comb begin
                if (sat_p[k] && ovf_s) begin
                    res_s = {a_p[k][WIDTH-1], {(WIDTH-1){~a_p[k][WIDTH-1]}}};
                end else begin
                    res_s = sum_s;
                end
            end
`else
            assign res_s = sum_s;
`endif

            // Output register stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_sum_q   <= {WIDTH{1'b0}};
                    out_carry_q <= 1'b0;
                    out_ovf_q   <= 1'b0;
                    out_zero_q  <= 1'b0;
                end else if (adv_s) begin
                    out_valid_q <= v_p[k];
                    out_sum_q   <= res_s;
                    out_carry_q <= sl_c_s;
                    out_ovf_q   <= ovf_s;
                    out_zero_q  <= (res_s == {WIDTH{1'b0}});
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] sum_s_fwd(input logic [WIDTH-1:0] s);
        sum_s_fwd = s;
    endfunction

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vector table, stall/reset sequences on a
// 2-stage instance, and random streams on 1- and 4-stage instances.
`timescale 1ns/1ps
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W = 32;
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [W-1:0] d2_a, d2_b, d2_sum;
    logic [1:0]   d2_op;
    logic         d2_carry, d2_ovf, d2_zero;

    logic         d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [W-1:0] d1_a, d1_b, d1_sum;
    logic [1:0]   d1_op;
    logic         d1_carry, d1_ovf, d1_zero;

    logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [W-1:0] d4_a, d4_b, d4_sum;
    logic [1:0]   d4_op;
    logic         d4_carry, d4_ovf, d4_zero;

    pipelined_adder #(.WIDTH(W), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_a(d2_a), .in_b(d2_b), .in_op(d2_op), .out_valid(d2_out_valid),
        .out_ready(d2_out_ready), .out_sum(d2_sum), .out_carry(d2_carry),
        .out_ovf(d2_ovf), .out_zero(d2_zero));

    pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_a), .in_b(d1_b), .in_op(d1_op), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .out_sum(d1_sum), .out_carry(d1_carry),
        .out_ovf(d1_ovf), .out_zero(d1_zero));

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .in_a(d4_a), .in_b(d4_b), .in_op(d4_op), .out_valid(d4_out_valid),
        .out_ready(d4_out_ready), .out_sum(d4_sum), .out_carry(d4_carry),
        .out_ovf(d4_ovf), .out_zero(d4_zero));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model built on signed 64-bit arithmetic, independent of slicing.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic [34:0] res);
        longint sa, sb, r;
        logic [32:0] u;
        logic [31:0] s;
        logic c, o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[0]) begin
            r = sa - sb;
            u = {1'b0, a} - {1'b0, b};
            c = (a >= b);
        end else begin
            r = sa + sb;
            u = {1'b0, a} + {1'b0, b};
            c = u[32];
        end
        s = u[31:0];
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SAT_EN
        if (op[1] && o) s = (r > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        res = {c, o, (s == 32'h0000_0000), s};
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t vt [10];
    logic [31:0] qa [8];
    logic [31:0] qb [8];
    logic [1:0]  qop [8];
    logic [31:0] ra [N_RAND];
    logic [31:0] rb [N_RAND];
    logic [1:0]  rop [N_RAND];

    initial begin
        logic [34:0] e;
        logic [31:0] held;
        logic stalled_prev;
        int sent, got, idx;

        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[2] = '{32'h1234_5678, 32'h1111_1111, 2'b00, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[4] = '{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[5] = '{32'h0000_FFFF, 32'h0000_0001, 2'b00, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vt[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
`ifdef PIPELINED_ADDER_SAT_EN
        vt[7] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vt[8] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        vt[7] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[8] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 2'b10, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 8; i++) begin
            qa[i]  = 32'h1F00_0000 * i + 32'h0000_FFF0 + i;
            qb[i]  = 32'h0000_0013 * i + 32'h0000_0010;
            qop[i] = 2'(i);
        end
        for (int i = 0; i < N_RAND; i++) begin
            ra[i]  = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            rb[i]  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rop[i] = 2'($urandom_range(0, 3));
        end

        rst = 1'b1;
        d2_in_valid = 1'b0; d2_a = '0; d2_b = '0; d2_op = 2'b00; d2_out_ready = 1'b1;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_op = 2'b00; d1_out_ready = 1'b1;
        d4_in_valid = 1'b0; d4_a = '0; d4_b = '0; d4_op = 2'b00; d4_out_ready = 1'b1;
        #1;
        chk("rst_in_ready", d2_in_ready, 1);
        chk("rst_out_valid", d2_out_valid, 0);
        chk("rst_out_fields", {d2_carry, d2_ovf, d2_zero, d2_sum}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table, one beat at a time: latency must be exactly 2.
        for (int i = 0; i < 10; i++) begin
            chk("vec_in_ready", d2_in_ready, 1);
            d2_in_valid = 1'b1; d2_a = vt[i].a; d2_b = vt[i].b; d2_op = vt[i].op;
            @(posedge clk); #1;
            d2_in_valid = 1'b0;
            chk("vec_not_early", d2_out_valid, 0);
            @(posedge clk); #1;
            chk("vec_valid", d2_out_valid, 1);
            chk("vec_result", {d2_carry, d2_ovf, d2_zero, d2_sum},
                {vt[i].c, vt[i].o, vt[i].z, vt[i].s});
            @(posedge clk); #1;
            chk("vec_drained", d2_out_valid, 0);
        end

        // Back-to-back 8 beats with out_ready low on cycles 3..5.
        sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            idx = (sent < 8) ? sent : 0;
            d2_out_ready = !(cyc >= 3 && cyc <= 5);
            d2_in_valid = (sent < 8);
            d2_a = qa[idx]; d2_b = qb[idx]; d2_op = qop[idx];
            #1;
            if (stalled_prev) chk("stall_hold", d2_sum, held);
            if (d2_out_valid && !d2_out_ready) begin
                chk("stall_in_ready", d2_in_ready, 0);
                held = d2_sum;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (d2_out_ready) chk("simul_in_ready", d2_in_ready, 1);
            if (d2_out_valid && d2_out_ready) begin
                model(qa[got], qb[got], qop[got], e);
                chk("seq_result", {d2_carry, d2_ovf, d2_zero, d2_sum}, e);
                got++;
            end
            if (d2_in_valid && d2_in_ready) sent++;
            @(posedge clk); #1;
        end
        d2_in_valid = 1'b0; d2_out_ready = 1'b1;
        chk("seq_got", got, 8);
        chk("seq_sent", sent, 8);
        #1;
        chk("seq_no_dup", d2_out_valid, 0);
        @(posedge clk); #1;
        chk("seq_no_dup2", d2_out_valid, 0);

        // Reset with two beats in flight.
        d2_in_valid = 1'b1; d2_a = 32'h0000_0011; d2_b = 32'h0000_0022; d2_op = 2'b00;
        @(posedge clk); #1;
        d2_a = 32'h0000_0100; d2_b = 32'h0000_0200;
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        chk("pre_rst_valid", d2_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", d2_out_valid, 0);
        chk("rst_async_fields", {d2_carry, d2_ovf, d2_zero, d2_sum}, 0);
        chk("rst_async_in_ready", d2_in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_stale", d2_out_valid, 0);
            @(posedge clk); #1;
        end
        d2_in_valid = 1'b1; d2_a = 32'h0000_0003; d2_b = 32'h0000_0004; d2_op = 2'b01;
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        chk("post_rst_not_early", d2_out_valid, 0);
        @(posedge clk); #1;
        chk("post_rst_valid", d2_out_valid, 1);
        chk("post_rst_result", {d2_carry, d2_ovf, d2_zero, d2_sum},
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
        @(posedge clk); #1;

        // Random streams on 1- and 4-stage instances, one beat per cycle.
        for (int cyc = 0; cyc < N_RAND + 6; cyc++) begin
            if (cyc >= 1 && cyc - 1 < N_RAND) begin
                model(ra[cyc-1], rb[cyc-1], rop[cyc-1], e);
                chk("s1_valid", d1_out_valid, 1);
                chk("s1_result", {d1_carry, d1_ovf, d1_zero, d1_sum}, e);
            end else begin
                chk("s1_idle", d1_out_valid, 0);
            end
            if (cyc >= 4 && cyc - 4 < N_RAND) begin
                model(ra[cyc-4], rb[cyc-4], rop[cyc-4], e);
                chk("s4_valid", d4_out_valid, 1);
                chk("s4_result", {d4_carry, d4_ovf, d4_zero, d4_sum}, e);
            end else begin
                chk("s4_idle", d4_out_valid, 0);
            end
            idx = (cyc < N_RAND) ? cyc : 0;
            d1_in_valid = (cyc < N_RAND);
            d1_a = ra[idx]; d1_b = rb[idx]; d1_op = rop[idx];
            d4_in_valid = (cyc < N_RAND);
            d4_a = ra[idx]; d4_b = rb[idx]; d4_op = rop[idx];
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
